// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared definitions for the programmable clock divider.
//   ch_state_e   - per-channel FSM state (IDLE, RUN, DRAIN)
//   CNT_W_DEF    - default counter / divide width
//   DEF_DIV_DEF  - default divide value loaded at reset
package clk_div_pkg;

  localparam int          CNT_W_DEF   = 26;
  localparam logic [25:0] DEF_DIV_DEF = 26'd25000000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } ch_state_e;

endpackage

// File: rtl/clk_div_ch.sv
// clk_div_ch: one divider channel.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   en                - level-sensitive run enable
//   ld, ld_val        - one-cycle strobe writing a new divide (half-period - 1)
//   new_clk           - divided clock, registered
//   tick              - high for the cycle right after new_clk has risen
//   active            - channel is in RUN or DRAIN
//   state             - current FSM state, for observation
//
// ld is a plain strobe with no back-pressure: the value is always accepted
// in the cycle ld is high. It lands in div_pend; div_act only follows it at
// a terminal count (or immediately while IDLE), so a running half-period is
// never shortened or stretched mid-way.
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int               CNT_W   = CNT_W_DEF,
  parameter logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEF_DIV_DEF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             ld,
  input  logic [CNT_W-1:0] ld_val,
  output logic             new_clk,
  output logic             tick,
  output logic             active,
  output ch_state_e        state
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div_act;
  logic [CNT_W-1:0] div_pend;
  logic             tc;

  // cnt never exceeds div_act: div_act only changes while cnt is 0
  // (IDLE, or the same edge that clears cnt at terminal count).
  assign tc     = (cnt == div_act);
  assign active = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      div_act  <= DEF_DIV;
      div_pend <= DEF_DIV;
      new_clk  <= 1'b0;
      tick     <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (ld) div_pend <= ld_val;

      unique case (state)
        IDLE: begin
          cnt     <= '0;
          new_clk <= 1'b0;
          if (ld) div_act <= ld_val;
          if (en) state <= RUN;
        end

        RUN: begin
          if (!en && !new_clk) begin
            // Low phase: stopping here cannot produce a runt pulse.
            state <= IDLE;
            cnt   <= '0;
          end else if (tc) begin
            cnt     <= '0;
            new_clk <= ~new_clk;
            tick    <= ~new_clk;
            div_act <= div_pend;
            // Disabled exactly as the high phase ends: already done draining.
            if (!en) state <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (!en) state <= DRAIN;
          end
        end

        DRAIN: begin
          // new_clk is high throughout DRAIN; finish the high phase first.
          if (tc) begin
            cnt     <= '0;
            new_clk <= 1'b0;
            div_act <= div_pend;
            state   <= en ? RUN : IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (en) state <= RUN;
          end
        end

        default: begin
          state   <= IDLE;
          cnt     <= '0;
          new_clk <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/clk_div_prog.sv
// clk_div_prog: N_CH independent programmable clock dividers.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   en[N_CH]                 - per-channel run enable
//   div_ld, div_ch, div_val  - one-cycle load of a divide value into div_ch
//   new_clk[N_CH]            - divided clocks
//   tick[N_CH]               - rising-edge pulses of new_clk
//   active[N_CH]             - channel not IDLE
//   state_dbg[2*N_CH]        - per-channel FSM state, channel i at [2i+1:2i]
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int               N_CH    = 4,
  parameter int               CNT_W   = CNT_W_DEF,
  parameter logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEF_DIV_DEF),
  localparam int              CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   en,
  input  logic              div_ld,
  input  logic [CH_W-1:0]   div_ch,
  input  logic [CNT_W-1:0]  div_val,
  output logic [N_CH-1:0]   new_clk,
  output logic [N_CH-1:0]   tick,
  output logic [N_CH-1:0]   active,
  output logic [2*N_CH-1:0] state_dbg
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic      ld_i;
    ch_state_e st_i;

    // Exact-match decode: a div_ch value >= N_CH matches no channel and
    // the load is dropped.
    assign ld_i = div_ld && (int'(div_ch) == i);

    clk_div_ch #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .en      (en[i]),
      .ld      (ld_i),
      .ld_val  (div_val),
      .new_clk (new_clk[i]),
      .tick    (tick[i]),
      .active  (active[i]),
      .state   (st_i)
    );

    assign state_dbg[2*i +: 2] = st_i;
  end

endmodule

// File: tb/tb_clk_div_prog.sv
// tb_clk_div_prog: directed and randomized checks of clk_div_prog.
module tb_clk_div_prog;
  import clk_div_pkg::*;

  localparam int         NC    = 4;
  localparam int         W     = 8;
  localparam logic [7:0] DEF   = 8'd5;
  localparam int         DEF_H = 6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [NC-1:0]   en;
  logic            div_ld;
  logic [1:0]      div_ch;
  logic [W-1:0]    div_val;
  logic [NC-1:0]   new_clk, tick, active;
  logic [2*NC-1:0] state_dbg;

  clk_div_prog #(.N_CH(NC), .CNT_W(W), .DEF_DIV(DEF)) u_dut (
    .clk(clk), .rst(rst), .en(en), .div_ld(div_ld), .div_ch(div_ch),
    .div_val(div_val), .new_clk(new_clk), .tick(tick), .active(active),
    .state_dbg(state_dbg)
  );

  // Second instance with 5 channels so div_ch can carry out-of-range codes.
  logic [4:0] en5, new_clk5, tick5, active5;
  logic       div_ld5;
  logic [2:0] div_ch5;
  logic [W-1:0] div_val5;
  logic [9:0] state_dbg5;

  clk_div_prog #(.N_CH(5), .CNT_W(W), .DEF_DIV(DEF)) u_dut5 (
    .clk(clk), .rst(rst), .en(en5), .div_ld(div_ld5), .div_ch(div_ch5),
    .div_val(div_val5), .new_clk(new_clk5), .tick(tick5), .active(active5),
    .state_dbg(state_dbg5)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Event-level view of each channel: output level, absolute edge number of
  // the next toggle, and active/pending half-period lengths in cycles.
  // mode: 0 = stopped, 1 = running, 2 = finishing its high phase.
  int m_mode [NC];
  int m_level[NC];
  int m_tick [NC];
  int m_cur  [NC];
  int m_pend [NC];
  int m_next [NC];

  task automatic model_edge();
    int  v;
    int  mode0;
    bit  ld_c, en_c, tc;
    cyc++;
    v = int'(div_val) + 1;
    for (int c = 0; c < NC; c++) begin
      ld_c = div_ld && (int'(div_ch) == c);
      en_c = en[c];
      m_tick[c] = 0;
      if (rst) begin
        m_mode[c] = 0; m_level[c] = 0;
        m_cur[c] = DEF_H; m_pend[c] = DEF_H; m_next[c] = 0;
      end else if (m_mode[c] == 0) begin
        if (ld_c) begin m_cur[c] = v; m_pend[c] = v; end
        if (en_c) begin m_mode[c] = 1; m_next[c] = cyc + m_cur[c]; end
      end else begin
        mode0 = m_mode[c];
        tc = (cyc == m_next[c]);
        if (mode0 == 1 && !en_c && m_level[c] == 0) begin
          m_mode[c] = 0;
        end else begin
          if (tc) begin
            // New length takes effect only at the end of a half-period,
            // using whatever was pending before this edge.
            m_level[c] = 1 - m_level[c];
            m_tick[c]  = m_level[c];
            m_cur[c]   = m_pend[c];
            m_next[c]  = cyc + m_cur[c];
          end
          if (en_c)                 m_mode[c] = 1;
          else if (m_level[c] == 0) m_mode[c] = 0;
          else                      m_mode[c] = 2;
        end
        if (ld_c) m_pend[c] = v;
      end
    end
  endtask

  // ---------------- driver ----------------
  // Inputs change 1 time unit after the edge; outputs are sampled there too.
  task automatic step();
    logic [NC-1:0]   e_clk, e_tick, e_act;
    logic [2*NC-1:0] e_st;
    @(posedge clk);
    model_edge();
    #1;
    for (int c = 0; c < NC; c++) begin
      e_clk[c]  = (m_level[c] != 0);
      e_tick[c] = (m_tick[c] != 0);
      e_act[c]  = (m_mode[c] != 0);
      e_st[2*c +: 2] = (m_mode[c] == 0) ? IDLE : (m_mode[c] == 1) ? RUN : DRAIN;
    end
    chk("model_new_clk", 32'(new_clk), 32'(e_clk));
    chk("model_tick",    32'(tick),    32'(e_tick));
    chk("model_active",  32'(active),  32'(e_act));
    chk("model_state",   32'(state_dbg), 32'(e_st));
  endtask

  task automatic wait_rise(input int c);
    int n;
    n = 0;
    while (tick[c] !== 1'b1 && n < 64) begin
      step();
      n++;
    end
    chk("wait_rise", 32'(tick[c]), 32'd1);
  endtask

  task automatic measure_period(input int c, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (tick[c] !== 1'b1 && n < 64);
  endtask

  // ---------------- stimulus ----------------
  int n, hi, r2, r3, h;
  logic [4:0] e5_clk, e5_tick;

  initial begin
    en = '0; div_ld = 1'b0; div_ch = '0; div_val = '0;
    en5 = '0; div_ld5 = 1'b0; div_ch5 = '0; div_val5 = '0;

    // Reset wins over a simultaneous enable and load.
    rst = 1'b1; en = '1; div_ld = 1'b1; div_ch = 2'd0; div_val = 8'd1;
    step();
    rst = 1'b0; en = '0; div_ld = 1'b0;
    chk("rst_new_clk", 32'(new_clk), 32'd0);
    chk("rst_tick",    32'(tick),    32'd0);
    chk("rst_active",  32'(active),  32'd0);

    // Every channel starts with the default divide: first rise 6 edges in.
    en = 4'hF;
    step();
    repeat (5) step();
    chk("def_pre_rise", 32'(new_clk), 32'd0);
    step();
    chk("def_rise",      32'(new_clk), 32'hF);
    chk("def_rise_tick", 32'(tick),    32'hF);
    repeat (20) step();
    en = '0;
    repeat (8) step();
    rst = 1'b1; step(); rst = 1'b0;

    // ch0 divide 3: first rise 4 edges after RUN entry, period 8, 50% duty.
    div_ld = 1'b1; div_ch = 2'd0; div_val = 8'd3;
    step();
    div_ld = 1'b0; en[0] = 1'b1;
    step();
    chk("ch0_run_entry", 32'(active[0]), 32'd1);
    repeat (3) step();
    chk("ch0_pre_rise", 32'(new_clk[0]), 32'd0);
    step();
    chk("ch0_first_rise", 32'(new_clk[0]), 32'd1);
    chk("ch0_first_tick", 32'(tick[0]),    32'd1);
    measure_period(0, n);
    chk("ch0_tick_period", 32'(n), 32'd8);
    hi = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      hi += int'(new_clk[0]);
    end
    chk("ch0_duty_high", 32'(hi), 32'd4);

    // ch1 divide 0: toggles every cycle, tick every other cycle.
    div_ld = 1'b1; div_ch = 2'd1; div_val = 8'd0;
    step();
    div_ld = 1'b0; en[1] = 1'b1;
    step();
    step();
    chk("ch1_rise_a", 32'(new_clk[1]), 32'd1);
    chk("ch1_tick_a", 32'(tick[1]),    32'd1);
    step();
    chk("ch1_fall",   32'(new_clk[1]), 32'd0);
    chk("ch1_tick_b", 32'(tick[1]),    32'd0);
    step();
    chk("ch1_rise_b", 32'(new_clk[1]), 32'd1);
    chk("ch1_tick_c", 32'(tick[1]),    32'd1);

    // ch2/ch3: random divides, load and enable in overlapping cycles.
    r2 = $urandom_range(0, 6);
    r3 = $urandom_range(0, 6);
    div_ld = 1'b1; div_ch = 2'd3; div_val = 8'(r3);
    step();
    div_ch = 2'd2; div_val = 8'(r2); en[3] = 1'b1;
    step();
    div_ld = 1'b0; en[2] = 1'b1;
    step();
    wait_rise(3);
    measure_period(3, n);
    chk("ch3_period", 32'(n), 32'(2 * (r3 + 1)));
    wait_rise(2);
    measure_period(2, n);
    chk("ch2_period", 32'(n), 32'(2 * (r2 + 1)));
    measure_period(1, n);
    chk("ch1_period", 32'(n), 32'd2);

    // ch0 (div 3): load div 1 mid-half; current half keeps 4 cycles.
    wait_rise(0);
    step();
    div_ld = 1'b1; div_ch = 2'd0; div_val = 8'd1;
    step();
    div_ld = 1'b0;
    step(); chk("mid_ld_still_high", 32'(new_clk[0]), 32'd1);
    step(); chk("mid_ld_fall_r4",    32'(new_clk[0]), 32'd0);
    step(); chk("mid_ld_low_r5",     32'(new_clk[0]), 32'd0);
    step(); chk("mid_ld_rise_r6",    32'(new_clk[0]), 32'd1);
    step(); chk("mid_ld_high_r7",    32'(new_clk[0]), 32'd1);
    step(); chk("mid_ld_fall_r8",    32'(new_clk[0]), 32'd0);

    // Load coincident with a terminal count: applies one half-period later.
    wait_rise(0);
    step();
    div_ld = 1'b1; div_ch = 2'd0; div_val = 8'd3;
    step(); chk("tc_ld_fall", 32'(new_clk[0]), 32'd0);
    div_ld = 1'b0;
    step(); chk("tc_ld_low",   32'(new_clk[0]), 32'd0);
    step(); chk("tc_ld_rise",  32'(new_clk[0]), 32'd1);
    repeat (3) step();
    chk("tc_ld_long_high", 32'(new_clk[0]), 32'd1);
    step(); chk("tc_ld_fall_t8", 32'(new_clk[0]), 32'd0);

    // Drop en[0] at cnt=1 of a high phase: high phase completes, then IDLE.
    wait_rise(0);
    step();
    en[0] = 1'b0;
    step();
    chk("drain_state",  32'(state_dbg[1:0]), 32'(DRAIN));
    chk("drain_high",   32'(new_clk[0]),     32'd1);
    chk("drain_active", 32'(active[0]),      32'd1);
    step(); chk("drain_high_r3", 32'(new_clk[0]), 32'd1);
    step();
    chk("drain_done_clk",    32'(new_clk[0]),     32'd0);
    chk("drain_done_active", 32'(active[0]),      32'd0);
    chk("drain_done_state",  32'(state_dbg[1:0]), 32'(IDLE));

    // Random enables, loads and occasional resets against the model.
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 149) == 0);
      for (int c = 0; c < NC; c++)
        if ($urandom_range(0, 9) == 0) en[c] = ~en[c];
      div_ld  = ($urandom_range(0, 3) == 0);
      div_ch  = 2'($urandom_range(0, 3));
      div_val = 8'($urandom_range(0, 5));
      step();
    end
    rst = 1'b0; div_ld = 1'b0;

    // Reset in the middle of a high phase, enables held high throughout.
    rst = 1'b1; step(); rst = 1'b0;
    div_ld = 1'b1; div_ch = 2'd0; div_val = 8'd3;
    step();
    div_ld = 1'b0; en = 4'hF;
    step();
    wait_rise(0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_new_clk", 32'(new_clk),   32'd0);
    chk("mid_rst_tick",    32'(tick),      32'd0);
    chk("mid_rst_active",  32'(active),    32'd0);
    chk("mid_rst_state",   32'(state_dbg), 32'd0);
    step();
    repeat (5) step();
    chk("mid_rst_def_pre", 32'(new_clk), 32'd0);
    step();
    chk("mid_rst_def_rise", 32'(new_clk), 32'hF);
    chk("mid_rst_def_tick", 32'(tick),    32'hF);
    en = '0;
    repeat (8) step();

    // Out-of-range channel codes on the 5-channel instance are ignored.
    rst = 1'b1; step(); rst = 1'b0;
    div_ld5 = 1'b1; div_val5 = 8'd0;
    div_ch5 = 3'd5; step();
    div_ch5 = 3'd6; step();
    div_ch5 = 3'd7; step();
    div_ch5 = 3'd4; div_val5 = 8'd1; step();
    div_ld5 = 1'b0; en5 = 5'h1F;
    step();
    chk("oor_active", 32'(active5), 32'h1F);
    for (int j = 1; j <= 12; j++) begin
      step();
      for (int c = 0; c < 5; c++) begin
        h = (c == 4) ? 2 : DEF_H;
        e5_clk[c]  = ((j / h) % 2) == 1;
        e5_tick[c] = (j % (2 * h)) == h;
      end
      chk("oor_new_clk", 32'(new_clk5), 32'(e5_clk));
      chk("oor_tick",    32'(tick5),    32'(e5_tick));
    end
    en5 = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
